alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 46 ++++
 rtl/alu_seq_divider.sv | 61 ++++++
 rtl/alu_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared ALU opcode encodings, flag bundle and opcode-class helpers.
package alu_seq_pkg;

    localparam int unsigned OP_W = 5;

    // Opcode encodings shared by every block that drives or decodes alu_op.
    localparam logic [OP_W-1:0] ALU_PUR = 5'd0;   // pass operand_a through
    localparam logic [OP_W-1:0] ALU_SHL = 5'd1;
    localparam logic [OP_W-1:0] ALU_SHR = 5'd2;
    localparam logic [OP_W-1:0] ALU_UAD = 5'd3;
    localparam logic [OP_W-1:0] ALU_SAD = 5'd4;
    localparam logic [OP_W-1:0] ALU_SSB = 5'd5;
    localparam logic [OP_W-1:0] ALU_AND = 5'd6;
    localparam logic [OP_W-1:0] ALU_OR  = 5'd7;
    localparam logic [OP_W-1:0] ALU_XOR = 5'd8;
    localparam logic [OP_W-1:0] ALU_UNC = 5'd9;
    localparam logic [OP_W-1:0] ALU_EQ  = 5'd10;
    localparam logic [OP_W-1:0] ALU_ULT = 5'd11;
    localparam logic [OP_W-1:0] ALU_SLT = 5'd12;
    localparam logic [OP_W-1:0] ALU_ULE = 5'd13;
    localparam logic [OP_W-1:0] ALU_SLE = 5'd14;
    localparam logic [OP_W-1:0] ALU_UMT = 5'd15;
    localparam logic [OP_W-1:0] ALU_SMT = 5'd16;
    localparam logic [OP_W-1:0] ALU_SDV = 5'd17;
    localparam logic [OP_W-1:0] ALU_UDV = 5'd18;

    // Status flags that update and hold together with the result.
    typedef struct packed {
        logic shift_ovf;
        logic arith_ovf;
        logic div_zero;
    } alu_flags_t;

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == ALU_UMT) || (op == ALU_SMT);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == ALU_UDV) || (op == ALU_SDV);
    endfunction

    function automatic logic is_signed_long_op(input logic [OP_W-1:0] op);
        return (op == ALU_SMT) || (op == ALU_SDV);
    endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// alu_seq_divider: unsigned restoring divider, one quotient bit per cycle, WIDTH cycles.
// done_c and quotient_c are combinational so the caller can capture the final
// quotient on the same edge as the last iteration.
module alu_seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done_c,
    output logic [WIDTH-1:0] quotient_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_shift;

    // One restoring step per cycle while the counter is non-zero.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        done_c    = 1'b0;
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            cnt_d = CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            if (rem_shift >= {1'b0, divisor}) begin
                rem_d = WIDTH'(rem_shift - {1'b0, divisor});
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d  = cnt_q - CNT_W'(1);
            done_c = (cnt_q == CNT_W'(1));
        end
        quotient_c = quo_d;
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU; single-cycle ops, shift-add multiply, restoring divide.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             shift_overflow,
    output logic             arithmetic_overflow,
    output logic             div_by_zero
);

    import alu_seq_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXEC1 = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [WIDTH-1:0] SMIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0]    MAG_LIMIT = PW'(SMIN);

    logic [2:0]       state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             signed_op;
    logic             neg_res;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] sr_result;
    alu_flags_t       sr_flags;
    logic [PW-1:0]    acc_step;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_ovf;
    logic [WIDTH-1:0] div_res;
    logic             div_ovf;
    logic             div_start_c;
    logic             div_done_c;
    logic [WIDTH-1:0] div_quot_c;

    // Operand magnitudes and single-cycle op results from the latched operands.
    always_comb begin
        signed_op = is_signed_long_op(op_q);
        neg_res   = signed_op && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        a_mag     = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag     = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;
        sum_w     = {1'b0, a_q} + {1'b0, b_q};
        diff_w    = a_q - b_q;
        sr_result = '0;
        sr_flags  = '0;
        case (op_q)
            ALU_PUR: sr_result = a_q;
            ALU_SHL: begin
                sr_result          = {a_q[WIDTH-2:0], 1'b0};
                sr_flags.shift_ovf = a_q[WIDTH-1];
            end
            ALU_SHR: begin
                sr_result          = {1'b0, a_q[WIDTH-1:1]};
                sr_flags.shift_ovf = a_q[0];
            end
            ALU_UAD: begin
                sr_result          = sum_w[WIDTH-1:0];
                sr_flags.arith_ovf = sum_w[WIDTH];
            end
            ALU_SAD: begin
                sr_result          = sum_w[WIDTH-1:0];
                sr_flags.arith_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1])
                                  && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_SSB: begin
                sr_result          = diff_w;
                sr_flags.arith_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1])
                                  && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_AND: sr_result = a_q & b_q;
            ALU_OR:  sr_result = a_q | b_q;
            ALU_XOR: sr_result = a_q ^ b_q;
            ALU_UNC: sr_result = {{(WIDTH-1){1'b0}}, 1'b1};
            ALU_EQ:  sr_result = {{(WIDTH-1){1'b0}}, a_q == b_q};
            ALU_ULT: sr_result = {{(WIDTH-1){1'b0}}, a_q < b_q};
            ALU_SLT: sr_result = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            ALU_ULE: sr_result = {{(WIDTH-1){1'b0}}, a_q <= b_q};
            ALU_SLE: sr_result = {{(WIDTH-1){1'b0}}, $signed(a_q) <= $signed(b_q)};
            default: begin
                sr_result = '0;
                sr_flags  = '0;
            end
        endcase
    end

    // Multiply step, final multiply/divide results and their overflow checks.
    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_lo   = neg_res ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        if (signed_op) begin
            mul_ovf = neg_res ? (acc_step > MAG_LIMIT) : (acc_step >= MAG_LIMIT);
        end else begin
            mul_ovf = |acc_step[PW-1:WIDTH];
        end
        div_res = neg_res ? -div_quot_c : div_quot_c;
        div_ovf = (op_q == ALU_SDV) && (a_q == SMIN) && (b_q == '1);
    end

    alu_seq_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk        (clk),
        .reset      (reset),
        .start      (div_start_c),
        .dividend   (a_mag),
        .divisor    (b_mag),
        .done_c     (div_done_c),
        .quotient_c (div_quot_c)
    );

    // Next-state, datapath and output-register update.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        div_start_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = alu_op;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    state_d = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (is_mul_op(op_q)) begin
                    acc_d    = '0;
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = S_MUL;
                end else if (is_div_op(op_q) && (b_q != '0)) begin
                    div_start_c = 1'b1;
                    state_d     = S_DIV;
                end else if (is_div_op(op_q)) begin
                    result_d          = '1;
                    flags_d           = '0;
                    flags_d.arith_ovf = 1'b1;
                    flags_d.div_zero  = 1'b1;
                    state_d           = S_DONE;
                end else begin
                    result_d = sr_result;
                    flags_d  = sr_flags;
                    state_d  = S_DONE;
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d          = mul_lo;
                    flags_d           = '0;
                    flags_d.arith_ovf = mul_ovf;
                    state_d           = S_DONE;
                end
            end
            S_DIV: begin
                if (div_done_c) begin
                    result_d          = div_res;
                    flags_d           = '0;
                    flags_d.arith_ovf = div_ovf;
                    state_d           = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign result              = result_q;
    assign shift_overflow      = flags_q.shift_ovf;
    assign arithmetic_overflow = flags_q.arith_ovf;
    assign div_by_zero         = flags_q.div_zero;

endmodule
